// File: rtl/e_mdu_pkg.sv
// ============================================================================
// Module      : e_mdu_pkg
// Description : Shared MDU operation codes, FSM state encodings and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package e_mdu_pkg;

    localparam logic [2:0] c_MDU_NONE  = 3'd0;
    localparam logic [2:0] c_MDU_MULT  = 3'd1;
    localparam logic [2:0] c_MDU_MULTU = 3'd2;
    localparam logic [2:0] c_MDU_DIV   = 3'd3;
    localparam logic [2:0] c_MDU_DIVU  = 3'd4;
    localparam logic [2:0] c_MDU_MTHI  = 3'd5;
    localparam logic [2:0] c_MDU_MTLO  = 3'd6;

    localparam logic [0:0] c_MDU_IDLE  = 1'b0;
    localparam logic [0:0] c_MDU_RUN   = 1'b1;

    function automatic logic is_mul(input logic [2:0] op);
        return (op == c_MDU_MULT) || (op == c_MDU_MULTU);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return (op == c_MDU_DIV) || (op == c_MDU_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/e_mdu_calc.sv
// ============================================================================
// Module      : e_mdu_calc
// Description : Combinational 64-bit multiply/divide result generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module e_mdu_calc
    import e_mdu_pkg::*;
(
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
);

    logic [63:0] w_prod_u;
    logic [63:0] w_prod_s;
    logic        w_signed_div;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_quo_mag;
    logic [31:0] w_rem_mag;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_prod_u = {32'd0, A} * {32'd0, B};
    // Low 64 bits of the product of sign-extended operands is the signed product.
    assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};

    // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign w_signed_div = (MDUOp == c_MDU_DIV);
    assign w_abs_a      = (w_signed_div && A[31]) ? (32'd0 - A) : A;
    assign w_abs_b      = (w_signed_div && B[31]) ? (32'd0 - B) : B;
    assign w_quo_mag    = (w_abs_b == 32'd0) ? 32'd0 : (w_abs_a / w_abs_b);
    assign w_rem_mag    = (w_abs_b == 32'd0) ? 32'd0 : (w_abs_a % w_abs_b);
    assign w_quo        = (w_signed_div && (A[31] ^ B[31])) ? (32'd0 - w_quo_mag) : w_quo_mag;
    assign w_rem        = (w_signed_div && A[31]) ? (32'd0 - w_rem_mag) : w_rem_mag;

    always_comb begin
        hi       = 32'd0;
        lo       = 32'd0;
        div_zero = 1'b0;
        case (MDUOp)
            c_MDU_MULT:  {hi, lo} = w_prod_s;
            c_MDU_MULTU: {hi, lo} = w_prod_u;
            c_MDU_DIV, c_MDU_DIVU: begin
                hi       = w_rem;
                lo       = w_quo;
                div_zero = (B == 32'd0);
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/e_mdu.sv
// ============================================================================
// Module      : e_mdu
// Description : E-stage multi-cycle multiply/divide unit with HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Done,
    output logic        Stall_req,
    output logic [31:0] HI_out,
    output logic [31:0] LO_out
);

    localparam int c_CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES - 1);

    logic [0:0]         r_state,   w_state_nxt;
    logic [c_CNT_W-1:0] r_count,   w_count_nxt;
    logic [31:0]        r_pend_hi, w_pend_hi_nxt;
    logic [31:0]        r_pend_lo, w_pend_lo_nxt;
    logic               r_dbz,     w_dbz_nxt;
    logic [31:0]        r_hi,      w_hi_nxt;
    logic [31:0]        r_lo,      w_lo_nxt;
    logic               r_busy,    w_busy_nxt;
    logic               r_done,    w_done_nxt;

    logic [31:0]        w_calc_hi;
    logic [31:0]        w_calc_lo;
    logic               w_calc_dbz;
    logic [c_CNT_W-1:0] w_load;

    e_mdu_calc u_calc (
        .MDUOp    (MDUOp),
        .A        (A),
        .B        (B),
        .hi       (w_calc_hi),
        .lo       (w_calc_lo),
        .div_zero (w_calc_dbz)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_pend_hi_nxt = r_pend_hi;
        w_pend_lo_nxt = r_pend_lo;
        w_dbz_nxt     = r_dbz;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_load        = is_mul(MDUOp) ? c_MULT_LOAD : c_DIV_LOAD;
        case (r_state)
            c_MDU_IDLE: begin
                if (Start) begin
                    if (MDUOp == c_MDU_MTHI) begin
                        w_hi_nxt = A;
                    end else if (MDUOp == c_MDU_MTLO) begin
                        w_lo_nxt = A;
                    end else if (is_mul(MDUOp) || is_div(MDUOp)) begin
                        if (w_load == '0) begin
                            // Single-cycle latency: commit straight from the calculator.
                            if (!w_calc_dbz) begin
                                w_hi_nxt = w_calc_hi;
                                w_lo_nxt = w_calc_lo;
                            end
                            w_done_nxt = 1'b1;
                        end else begin
                            w_pend_hi_nxt = w_calc_hi;
                            w_pend_lo_nxt = w_calc_lo;
                            w_dbz_nxt     = w_calc_dbz;
                            w_count_nxt   = w_load;
                            w_busy_nxt    = 1'b1;
                            w_state_nxt   = c_MDU_RUN;
                        end
                    end
                end
            end
            c_MDU_RUN: begin
                if (r_count == '0) begin
                    if (!r_dbz) begin
                        w_hi_nxt = r_pend_hi;
                        w_lo_nxt = r_pend_lo;
                    end
                    w_done_nxt  = 1'b1;
                    w_state_nxt = c_MDU_IDLE;
                end else begin
                    w_count_nxt = r_count - 1'b1;
                    // Busy drops one cycle ahead of commit so it spans exactly N-1 cycles.
                    w_busy_nxt  = (r_count != c_CNT_W'(1));
                end
            end
            default: w_state_nxt = c_MDU_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state   <= c_MDU_IDLE;
            r_count   <= '0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_dbz     <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_pend_hi <= w_pend_hi_nxt;
            r_pend_lo <= w_pend_lo_nxt;
            r_dbz     <= w_dbz_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign Busy      = r_busy;
    assign Done      = r_done;
    assign Stall_req = Start | r_busy;
    assign HI_out    = r_hi;
    assign LO_out    = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_e_mdu.sv
// ============================================================================
// Module      : tb_e_mdu
// Description : Scoreboard bench for e_mdu with directed multiply/divide vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_e_mdu;
    import e_mdu_pkg::*;

    localparam int c_MULT_N = 5;
    localparam int c_DIV_N  = 10;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [2:0]  MDUOp = c_MDU_NONE;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        Busy;
    logic        Done;
    logic        Stall_req;
    logic [31:0] HI_out;
    logic [31:0] LO_out;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        longint      t;
    } exp_t;

    exp_t q[$];
    int   compared = 0;
    int   failed   = 0;

    e_mdu #(.MULT_CYCLES(c_MULT_N), .DIV_CYCLES(c_DIV_N)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .Start     (Start),
        .MDUOp     (MDUOp),
        .A         (A),
        .B         (B),
        .Busy      (Busy),
        .Done      (Done),
        .Stall_req (Stall_req),
        .HI_out    (HI_out),
        .LO_out    (LO_out)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (Rst_n && Done) begin
            if (q.size() == 0) begin
                compared++;
                failed++;
                $display("FAIL unexpected_done: got Done=1 at %0t expected no pulse", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("commit_hi", {32'd0, HI_out}, {32'd0, e.hi});
                check("commit_lo", {32'd0, LO_out}, {32'd0, e.lo});
                check("commit_time", $time, e.t);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] eh, input logic [31:0] el,
                         input int n);
        exp_t e;
        @(negedge Clk);
        Start = 1'b1;
        MDUOp = op;
        A     = a;
        B     = b;
        #1 check("stall_start", {63'd0, Stall_req}, 64'd1);
        @(posedge Clk);
        if (push) begin
            e.hi = eh;
            e.lo = el;
            e.t  = $time + longint'(n) * 10 + 5;
            q.push_back(e);
        end
        #1;
        Start = 1'b0;
        MDUOp = c_MDU_NONE;
    endtask

    task automatic wait_done(input int nb, input string nm);
        bit seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge Clk);
            check({nm, "_busy"}, {63'd0, Busy}, {63'd0, (k < nb)});
            check({nm, "_stall"}, {63'd0, Stall_req}, {63'd0, (Start | (k < nb))});
            if (Done) seen = 1'b1;
        end
        if (!seen) begin
            compared++;
            failed++;
            $display("FAIL %s_timeout: got no Done expected Done within 40 cycles", nm);
        end else begin
            @(negedge Clk);
            check({nm, "_done_once"}, {63'd0, Done}, 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge Clk);
        #1 Rst_n = 1'b1;
        @(negedge Clk);
        check("rst_hi",    {32'd0, HI_out}, 64'd0);
        check("rst_lo",    {32'd0, LO_out}, 64'd0);
        check("rst_busy",  {63'd0, Busy}, 64'd0);
        check("rst_done",  {63'd0, Done}, 64'd0);
        check("rst_stall", {63'd0, Stall_req}, 64'd0);

        // Signed multiply -2 * 3
        issue(c_MDU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, c_MULT_N);
        wait_done(c_MULT_N - 1, "mult");

        // Unsigned multiply, then signed divide -7 / 2
        issue(c_MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'd1, 32'hFFFF_FFFE, c_MULT_N);
        wait_done(c_MULT_N - 1, "multu");
        issue(c_MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, c_DIV_N);
        wait_done(c_DIV_N - 1, "div_neg");

        issue(c_MDU_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'd1, 32'hFFFF_FFFD, c_DIV_N);
        wait_done(c_DIV_N - 1, "div_negb");
        issue(c_MDU_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, c_DIV_N);
        wait_done(c_DIV_N - 1, "divu");
        issue(c_MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, c_DIV_N);
        wait_done(c_DIV_N - 1, "div_ovf");

        // Direct HI/LO writes
        issue(c_MDU_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0, 32'd0, 32'd0, 0);
        @(negedge Clk);
        check("mthi_hi",   {32'd0, HI_out}, {32'd0, 32'hDEAD_BEEF});
        check("mthi_busy", {63'd0, Busy}, 64'd0);
        check("mthi_done", {63'd0, Done}, 64'd0);
        issue(c_MDU_MTHI, 32'h11, 32'd0, 1'b0, 32'd0, 32'd0, 0);
        issue(c_MDU_MTLO, 32'h22, 32'd0, 1'b0, 32'd0, 32'd0, 0);
        @(negedge Clk);
        check("mtlo_lo", {32'd0, LO_out}, 64'h22);
        check("mtlo_hi", {32'd0, HI_out}, 64'h11);

        // Divide by zero leaves HI/LO alone but still completes
        issue(c_MDU_DIVU, 32'd55, 32'd0, 1'b1, 32'h11, 32'h22, c_DIV_N);
        wait_done(c_DIV_N - 1, "divu_zero");

        // MTHI while a multiply is in flight is ignored
        issue(c_MDU_MULT, 32'd3, 32'd4, 1'b1, 32'd0, 32'd12, c_MULT_N);
        fork
            begin
                repeat (2) @(posedge Clk);
                #1;
                Start = 1'b1;
                MDUOp = c_MDU_MTHI;
                A     = 32'h0000_AAAA;
                @(posedge Clk);
                #1;
                Start = 1'b0;
                MDUOp = c_MDU_NONE;
            end
        join_none
        wait_done(c_MULT_N - 1, "mult_mthi");
        check("mthi_ignored", {32'd0, HI_out}, 64'd0);

        // Start with NONE does nothing
        issue(c_MDU_NONE, 32'd9, 32'd9, 1'b0, 32'd0, 32'd0, 0);
        @(negedge Clk);
        check("none_busy", {63'd0, Busy}, 64'd0);
        check("none_lo",   {32'd0, LO_out}, 64'd12);

        // Asynchronous reset in the middle of a divide
        issue(c_MDU_MTHI, 32'h55, 32'd0, 1'b0, 32'd0, 32'd0, 0);
        issue(c_MDU_DIV, 32'd100, 32'd3, 1'b0, 32'd0, 32'd0, 0);
        repeat (3) @(posedge Clk);
        #1 Rst_n = 1'b0;
        #1;
        check("arst_busy", {63'd0, Busy}, 64'd0);
        check("arst_done", {63'd0, Done}, 64'd0);
        check("arst_hi",   {32'd0, HI_out}, 64'd0);
        check("arst_lo",   {32'd0, LO_out}, 64'd0);
        @(posedge Clk);
        #1 Rst_n = 1'b1;
        repeat (15) begin
            @(negedge Clk);
            check("arst_no_done", {63'd0, Done}, 64'd0);
        end
        check("arst_hi_after", {32'd0, HI_out}, 64'd0);
        check("arst_lo_after", {32'd0, LO_out}, 64'd0);

        check("queue_empty", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

`default_nettype wire
